// File: rtl/debug_halt_ctrl.sv
// Debug halt controller for the 5-stage core.
// It drains the pipeline for a configurable depth and then holds the core halted.
// A halt is triggered by an EBREAK in decode or by a debugger request.
// It supports resume and single-step handshakes.
// Optional build macro: DBG_HALT_TIMEOUT_EN adds auto-resume after TIMEOUT_CYCLES halted cycles.
module debug_halt_ctrl #(
  parameter int XLEN           = 32,
  parameter int DRAIN_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            ext_halt_req,
  input  logic            resume_req,
  input  logic            step_req,
  output logic            halt_stall,
  output logic            halted,
  output logic [1:0]      halt_cause,
  output logic [XLEN-1:0] halt_pc,
  output logic            resume_ack,
  output logic            timeout
);

  localparam logic [XLEN-1:0] EBREAK_INSN = XLEN'(32'h0010_0073);
  localparam logic [3:0]      DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);

  localparam logic [1:0] CAUSE_EBREAK = 2'd1;
  localparam logic [1:0] CAUSE_EXT    = 2'd2;
  localparam logic [1:0] CAUSE_STEP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2,
    S_STEP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            mask_q, mask_d;
  logic [1:0]      halt_cause_q, halt_cause_d;
  logic [XLEN-1:0] halt_pc_q, halt_pc_d;

  logic            ebreak_hit;
  logic            ext_hit;
  logic            timeout_hit;
  logic            timeout_fire;

  // Triggers are qualified with rst_n so every output reads 0 while reset is held.
  assign ebreak_hit = rst_n && !mask_q && (instr_d == EBREAK_INSN);
  assign ext_hit    = rst_n && ext_halt_req;

`ifdef DBG_HALT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_hit = (state_q == S_HALTED) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout     = timeout_fire;

  // Halted-cycle counter; it is held at zero outside HALTED, so each entry starts fresh.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_HALTED) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Next-state and output decode; the IDLE trigger drives halt_stall combinationally.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    halt_cause_d = halt_cause_q;
    halt_pc_d    = halt_pc_q;
    halt_stall   = 1'b0;
    halted       = 1'b0;
    resume_ack   = 1'b0;
    timeout_fire = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ebreak_hit || ext_hit) begin
          halt_stall   = 1'b1;
          state_d      = S_DRAIN;
          halt_pc_d    = pc_d;
          halt_cause_d = ebreak_hit ? CAUSE_EBREAK : CAUSE_EXT;
          cnt_d        = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        halt_stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_HALTED;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HALTED: begin
        halt_stall = 1'b1;
        halted     = 1'b1;
        if (resume_req) begin
          resume_ack = 1'b1;
          state_d    = step_req ? S_STEP : S_IDLE;
        end else if (timeout_hit) begin
          resume_ack   = 1'b1;
          timeout_fire = 1'b1;
          state_d      = S_IDLE;
        end
        // The EBREAK that caused this halt still sits in decode; let it pass once.
        if (resume_ack && (halt_cause_q == CAUSE_EBREAK)) begin
          mask_d = 1'b1;
        end
      end
      S_STEP: begin
        state_d      = S_DRAIN;
        halt_cause_d = CAUSE_STEP;
        halt_pc_d    = pc_d;
        cnt_d        = DRAIN_LOAD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Once one instruction has moved out of decode, the mask has done its job.
    if (!halt_stall) begin
      mask_d = 1'b0;
    end
  end

  // State, drain counter, mask and captured halt information.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      mask_q       <= 1'b0;
      halt_cause_q <= 2'd0;
      halt_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      halt_cause_q <= halt_cause_d;
      halt_pc_q    <= halt_pc_d;
    end
  end

  assign halt_cause = halt_cause_q;
  assign halt_pc    = halt_pc_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Randomized bench for debug_halt_ctrl.
// The reference model tracks halt timing with absolute cycle numbers.
// These are the cycle at which halted rises, the first halted cycle, and the pending step cycle.
module tb_debug_halt_ctrl;

  localparam int XLEN    = 32;
  localparam int DRAIN   = 3;
  localparam int TIMEOUT = 8;
  localparam int NCYC    = 4000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef DBG_HALT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic            ext_halt_req;
  logic            resume_req;
  logic            step_req;
  logic            halt_stall;
  logic            halted;
  logic [1:0]      halt_cause;
  logic [XLEN-1:0] halt_pc;
  logic            resume_ack;
  logic            timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  bit          m_halted;
  int          m_halt_at;
  int          m_halted_since;
  int          m_step_at;
  bit          m_mask;
  logic [1:0]  m_cause;
  logic [31:0] m_pc;
  int          n_halts;
  int          n_steps;
  int          n_timeouts;

  debug_halt_ctrl #(
    .XLEN(XLEN),
    .DRAIN_CYCLES(DRAIN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_d(instr_d),
    .pc_d(pc_d),
    .ext_halt_req(ext_halt_req),
    .resume_req(resume_req),
    .step_req(step_req),
    .halt_stall(halt_stall),
    .halted(halted),
    .halt_cause(halt_cause),
    .halt_pc(halt_pc),
    .resume_ack(resume_ack),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_halted       = 1'b0;
    m_halt_at      = -1;
    m_halted_since = -1;
    m_step_at      = -1;
    m_mask         = 1'b0;
    m_cause        = 2'd0;
    m_pc           = 32'd0;
  endtask

  // Evaluate one cycle: compute the expected outputs from the current inputs.
  // Compare them, then advance the model across the coming clock edge.
  task automatic model_cycle();
    bit          e_stall;
    bit          e_halted;
    bit          e_ack;
    bit          e_tmo;
    bit          eb;
    bit          leave;
    logic [1:0]  e_cause;
    logic [31:0] e_pc;
    e_stall  = 1'b0;
    e_halted = 1'b0;
    e_ack    = 1'b0;
    e_tmo    = 1'b0;
    leave    = 1'b0;
    if (!rst_n) begin
      model_reset();
    end
    e_cause = m_cause;
    e_pc    = m_pc;
    if (!rst_n) begin
      // everything already cleared
    end else if (m_halted) begin
      e_halted = 1'b1;
      e_stall  = 1'b1;
      if (resume_req) begin
        e_ack = 1'b1;
        leave = 1'b1;
        if (step_req) begin
          m_step_at = cyc + 1;
        end
      end else if (TMO_EN && (cyc - m_halted_since == TIMEOUT - 1)) begin
        e_ack = 1'b1;
        e_tmo = 1'b1;
        leave = 1'b1;
        n_timeouts++;
      end
      if (leave) begin
        m_halted = 1'b0;
        if (m_cause == 2'd1) begin
          m_mask = 1'b1;
        end
        $display("[TB] cycle %0d leave halt cause=%0d pc=%08h step=%0d timeout=%0d",
                 cyc, m_cause, m_pc, (m_step_at == cyc + 1), e_tmo);
      end
    end else if (m_halt_at > cyc) begin
      e_stall = 1'b1;
    end else if (m_step_at == cyc) begin
      m_cause   = 2'd3;
      m_pc      = pc_d;
      m_halt_at = cyc + 1 + DRAIN;
      n_steps++;
    end else begin
      eb = (instr_d == EBREAK) && !m_mask;
      if (eb || ext_halt_req) begin
        e_stall   = 1'b1;
        m_cause   = eb ? 2'd1 : 2'd2;
        m_pc      = pc_d;
        m_halt_at = cyc + 1 + DRAIN;
        n_halts++;
        $display("[TB] cycle %0d halt trigger cause=%0d pc=%08h", cyc, m_cause, m_pc);
      end
    end

    check_eq("halt_stall", 64'(halt_stall), 64'(e_stall));
    check_eq("halted",     64'(halted),     64'(e_halted));
    check_eq("resume_ack", 64'(resume_ack), 64'(e_ack));
    check_eq("timeout",    64'(timeout),    64'(e_tmo));
    check_eq("halt_cause", 64'(halt_cause), 64'(e_cause));
    check_eq("halt_pc",    64'(halt_pc),    64'(e_pc));

    if (!e_stall) begin
      m_mask = 1'b0;
    end
    if (rst_n && (m_halt_at == cyc + 1)) begin
      m_halted       = 1'b1;
      m_halted_since = cyc + 1;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    instr_d      = 32'd0;
    pc_d         = 32'd0;
    ext_halt_req = 1'b0;
    resume_req   = 1'b0;
    step_req     = 1'b0;
    n_halts      = 0;
    n_steps      = 0;
    n_timeouts   = 0;
    model_reset();

    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        rst_n = 1'b0;
      end else begin
        rst_n = ($urandom_range(0, 249) != 0);
      end
      instr_d      = ($urandom_range(0, 3) == 0) ? EBREAK : $urandom;
      pc_d         = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 2) == 0) begin
        ext_halt_req = ($urandom_range(0, 7) == 0);
      end
      resume_req   = ($urandom_range(0, 9) == 0);
      step_req     = $urandom_range(0, 1) == 1;
      @(negedge clk);
      model_cycle();
      cyc++;
    end

    $display("[TB] halts=%0d steps=%0d timeouts=%0d", n_halts, n_steps, n_timeouts);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_halt_ctrl.md
Name: debug_halt_ctrl

Overview:
Parametrised debug halt controller for the 5-stage core. It generalises the fixed 3-cycle ebreak drain FSM into a configurable drain depth, and adds three things:
- an external halt request from the debugger
- a resume handshake
- single-step

It sits beside the hazard control in the processor top. Its halt_stall output is ORed into the fetch stall and the IF/ID enable.

Parameters:
- XLEN, 32, instruction/PC width.
- DRAIN_CYCLES, 3, cycles halt_stall is held before halted asserts; legal range 1..15.
- TIMEOUT_CYCLES, 1024, auto-resume limit; used only with the optional feature.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- instr_d  input  XLEN  instruction in the decode stage
- pc_d  input  XLEN  PC of instr_d
- ext_halt_req  input  1  level halt request from the debugger
- resume_req  input  1  single-cycle resume pulse from the debugger
- step_req  input  1  sampled with resume_req; 1 = execute one instruction then re-halt
- halt_stall  output  1  stall to fetch and IF/ID
- halted  output  1  pipeline drained, core halted
- halt_cause  output  2  0=none, 1=EBREAK, 2=EXT, 3=STEP
- halt_pc  output  XLEN  pc_d captured at halt entry
- resume_ack  output  1  one-cycle pulse on leaving HALTED
- timeout  output  1  one-cycle pulse on auto-resume

Behaviour:
- Reset values (async, rst_n low): state=IDLE, all outputs 0, drain counter 0, ebreak mask 0.
- EBREAK detection: instr_d == 32'h0010_0073, gated by the mask flag.
- States: IDLE, DRAIN, HALTED, STEP.
- IDLE:
  - Exits to DRAIN when EBREAK is detected or ext_halt_req=1. halt_stall is asserted combinationally in that same cycle.
  - On entry: halt_pc<=pc_d; halt_cause<=1 if EBREAK, else 2 (EBREAK wins when both occur together); counter<=DRAIN_CYCLES-1.
- DRAIN:
  - halt_stall=1; counter decrements each cycle.
  - At counter==0, go to HALTED next cycle.
  - Total stall cycles before halted rises = DRAIN_CYCLES+1; halted rises exactly DRAIN_CYCLES+1 cycles after the trigger cycle.
  - ext_halt_req and resume_req are ignored here.
- HALTED:
  - halted=1, halt_stall=1.
  - resume_req=1 and step_req=0: go to IDLE, pulse resume_ack.
  - resume_req=1 and step_req=1: go to STEP, pulse resume_ack.
  - resume_req pulses outside HALTED are dropped, never queued.
- STEP:
  - Lasts exactly one cycle with halt_stall=0, so one instruction advances from IF/ID.
  - Then goes to DRAIN with halt_cause<=3 and halt_pc<=pc_d as sampled in the STEP cycle.
- Ebreak mask:
  - Set on leaving HALTED when halt_cause==1.
  - Cleared after the first cycle with halt_stall=0.
  - Purpose: the stalled EBREAK still sitting in decode does not re-trigger; it proceeds as a NOP.
- ext_halt_req held high through a resume re-halts immediately from IDLE; this is legal and halt_cause=2.
- halt_cause and halt_pc hold their values until the next halt entry.
- Reset mid-drain or mid-halt returns to IDLE in the same cycle (async); the counter is cleared.
- halt_stall is a Moore output except for the IDLE trigger cycle, which is combinational from instr_d/ext_halt_req.

Optional Feature:
- Macro: DBG_HALT_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs while in HALTED.
  - After TIMEOUT_CYCLES cycles in HALTED with no resume_req, go to IDLE and pulse both timeout and resume_ack.
  - An ebreak mask is applied as for a normal resume.
  - The counter clears on every HALTED entry.
- Undefined: the timeout port is tied to 0, no counter is built, and HALTED waits indefinitely.

Test Plan:
- EBREAK, DRAIN_CYCLES=3: instr_d=32'h0010_0073 at pc_d=32'h0000_0040 in cycle T -> halt_stall=1 from T, halted=1 at T+4, halt_cause=1, halt_pc=32'h40.
- Resume after EBREAK: resume_req pulse while halted -> resume_ack=1 for one cycle, halt_stall=0 the next cycle, no re-halt while instr_d still holds 32'h0010_0073.
- Single-step: halted with cause 2; resume_req=1 and step_req=1 -> exactly one cycle with halt_stall=0, then re-drain, halted again after 4 more cycles, halt_cause=3, halt_pc = PC sampled in the step cycle.
- Simultaneous triggers: EBREAK and ext_halt_req=1 in the same cycle -> halt_cause=1. Pulse resume_req during DRAIN -> ignored, halted still rises on schedule.
- Reset mid-drain: rst_n low at T+2 -> halt_stall, halted and halt_cause are 0 asynchronously; after release the block sits in IDLE with no halted pulse.
- DBG_HALT_TIMEOUT_EN, TIMEOUT_CYCLES=8: halt and never resume -> after 8 cycles halted, timeout and resume_ack pulse together and the state returns to IDLE.
